// File: rtl/latch_write_arbiter_pkg.sv
// latch_write_arbiter_pkg: FSM encodings and default parameters for the latch write arbiter
package latch_write_arbiter_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    OPEN  = 3'd2,
    HOLD  = 3'd3,
    ACK   = 3'd4
  } state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_EN_CYCLES = 1;
endpackage

// File: rtl/latch_write_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick; on a tie the port other than rr_last wins
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic [1:0] gnt
);
  always_comb gnt = &req ? (rr_last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/latch_write_arbiter.sv
// latch_write_arbiter: two-writer round-robin sequencer for a gated D latch bank (setup/open/hold).
// Optional LATCH_VERIFY_EN adds lat_q readback and a sticky err flag.
module latch_write_arbiter
  import latch_write_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int EN_CYCLES = DEF_EN_CYCLES
) (
  input  logic             c,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] d0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d1,
  output logic             ack0,
  output logic             ack1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_en
`ifdef LATCH_VERIFY_EN
  ,
  input  logic [WIDTH-1:0] lat_q,
  output logic             err
`endif
);
  localparam int CW = $clog2(EN_CYCLES + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0] win, gnt_q;
  logic rr_last;
  rr_arb2 u_arb (.req({req1, req0}), .rr_last(rr_last), .gnt(win));
  always_comb
    state_n = state == IDLE  ? ((req0 | req1) ? SETUP : IDLE) :
              state == SETUP ? OPEN :
              state == OPEN  ? ((cnt == '0) ? HOLD : OPEN) :
              state == HOLD  ? ACK : IDLE;
  // lat_en comes straight from a flop so the latch enable can never glitch
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      lat_d   <= '0;
      lat_en  <= 1'b0;
      gnt_q   <= 2'b00;
      rr_last <= 1'b1;
    end else begin
      state  <= state_n;
      lat_en <= state_n == OPEN;
      if (state == SETUP) cnt <= CW'(EN_CYCLES - 1);
      else if (state == OPEN && cnt != '0) cnt <= cnt - CW'(1);
      if (state == IDLE && state_n == SETUP) begin
        gnt_q   <= win;
        lat_d   <= win[1] ? d1 : d0;
        rr_last <= win[1];
      end else if (state == ACK) gnt_q <= 2'b00;
    end
  end
  assign gnt  = gnt_q;
  assign busy = state != IDLE;
  assign ack0 = state == ACK && gnt_q[0];
  assign ack1 = state == ACK && gnt_q[1];
`ifdef LATCH_VERIFY_EN
  logic err_q, miss;
  assign miss = state == ACK && lat_q != lat_d;
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else err_q <= err_q | miss;
  end
  assign err = err_q | miss;
`endif
endmodule

// File: tb/tb_latch_write_arbiter.sv
// tb_latch_write_arbiter: table-driven check of sequencing, round-robin and reset corners
module tb_latch_write_arbiter;
  logic c = 1'b0, rst_n = 1'b0, req0 = 1'b0, req1 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0, lat_d;
  logic ack0, ack1, busy, lat_en;
  logic [1:0] gnt;
  int checks = 0, failures = 0;
`ifdef LATCH_VERIFY_EN
  logic [7:0] bank = '0, lat_q;
  logic err;
  always @* if (lat_en) bank = lat_d;
  assign lat_q = bank & 8'hFE;
`endif
  latch_write_arbiter #(.WIDTH(8), .EN_CYCLES(1)) dut (
    .c(c), .rst_n(rst_n), .req0(req0), .d0(d0), .req1(req1), .d1(d1),
    .ack0(ack0), .ack1(ack1), .gnt(gnt), .busy(busy), .lat_d(lat_d), .lat_en(lat_en)
`ifdef LATCH_VERIFY_EN
    , .lat_q(lat_q), .err(err)
`endif
  );
  always #5 c = ~c;
  typedef struct {
    logic rst;
    logic r0, r1;
    logic [7:0] a0, a1;
    logic [13:0] exp;
  } vec_t;
  vec_t v[21];
  function automatic logic [13:0] o(logic k0, logic k1, logic [1:0] g, logic b, logic e, logic [7:0] d);
    return {k0, k1, g, b, e, d};
  endfunction
  function automatic vec_t mk(logic rs, logic r0, logic r1, logic [7:0] a0, logic [7:0] a1, logic [13:0] e);
    vec_t t;
    t.rst = rs; t.r0 = r0; t.r1 = r1; t.a0 = a0; t.a1 = a1; t.exp = e;
    return t;
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endtask
  task automatic pulse_rst();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask
  initial begin
    v[0]  = mk(1, 1, 0, 8'hA5, 8'h00, o(0, 0, 2'b01, 1, 0, 8'hA5));
    v[1]  = mk(0, 1, 0, 8'hA5, 8'h00, o(0, 0, 2'b01, 1, 1, 8'hA5));
    v[2]  = mk(0, 1, 0, 8'hA5, 8'h00, o(0, 0, 2'b01, 1, 0, 8'hA5));
    v[3]  = mk(0, 1, 0, 8'hA5, 8'h00, o(1, 0, 2'b01, 1, 0, 8'hA5));
    v[4]  = mk(0, 0, 0, 8'hA5, 8'h00, o(0, 0, 2'b00, 0, 0, 8'hA5));
    v[5]  = mk(1, 1, 1, 8'h11, 8'h22, o(0, 0, 2'b01, 1, 0, 8'h11));
    v[6]  = mk(0, 1, 1, 8'h11, 8'h22, o(0, 0, 2'b01, 1, 1, 8'h11));
    v[7]  = mk(0, 1, 1, 8'h11, 8'h22, o(0, 0, 2'b01, 1, 0, 8'h11));
    v[8]  = mk(0, 1, 1, 8'h11, 8'h22, o(1, 0, 2'b01, 1, 0, 8'h11));
    v[9]  = mk(0, 1, 1, 8'h11, 8'h22, o(0, 0, 2'b00, 0, 0, 8'h11));
    v[10] = mk(0, 1, 1, 8'h11, 8'h22, o(0, 0, 2'b10, 1, 0, 8'h22));
    v[11] = mk(0, 1, 1, 8'h11, 8'h22, o(0, 0, 2'b10, 1, 1, 8'h22));
    v[12] = mk(0, 1, 1, 8'h11, 8'h22, o(0, 0, 2'b10, 1, 0, 8'h22));
    v[13] = mk(0, 1, 1, 8'h11, 8'h22, o(0, 1, 2'b10, 1, 0, 8'h22));
    v[14] = mk(0, 1, 1, 8'h11, 8'h22, o(0, 0, 2'b00, 0, 0, 8'h22));
    v[15] = mk(0, 1, 1, 8'h11, 8'h22, o(0, 0, 2'b01, 1, 0, 8'h11));
    v[16] = mk(1, 1, 0, 8'h3C, 8'h00, o(0, 0, 2'b01, 1, 0, 8'h3C));
    v[17] = mk(0, 1, 0, 8'h3C, 8'h00, o(0, 0, 2'b01, 1, 1, 8'h3C));
    v[18] = mk(0, 1, 0, 8'hFF, 8'h00, o(0, 0, 2'b01, 1, 0, 8'h3C));
    v[19] = mk(0, 1, 0, 8'hFF, 8'h00, o(1, 0, 2'b01, 1, 0, 8'h3C));
    v[20] = mk(0, 0, 0, 8'hFF, 8'h00, o(0, 0, 2'b00, 0, 0, 8'h3C));
    #2 chk("reset_outputs", {18'b0, ack0, ack1, gnt, busy, lat_en, lat_d}, 32'h0);
    @(posedge c); #1 rst_n = 1'b1;
    @(posedge c); #1;
    chk("idle_after_reset", {18'b0, ack0, ack1, gnt, busy, lat_en, lat_d}, 32'h0);
    for (int i = 0; i < 21; i++) begin
      if (v[i].rst) pulse_rst();
      req0 = v[i].r0; req1 = v[i].r1; d0 = v[i].a0; d1 = v[i].a1;
      @(posedge c); #1;
      chk($sformatf("vec%0d", i), {18'b0, ack0, ack1, gnt, busy, lat_en, lat_d}, {18'b0, v[i].exp});
    end
    pulse_rst();
    req0 = 1'b1; req1 = 1'b0; d0 = 8'h5A;
    @(posedge c); @(posedge c); #1;
    chk("mid_open_en", {31'b0, lat_en}, 32'h1);
    #1 rst_n = 1'b0;
    #1 chk("async_en_drop", {29'b0, lat_en, busy, ack0}, 32'h0);
    req0 = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge c); #1;
    chk("idle_after_release", {30'b0, busy, lat_en}, 32'h0);
    req0 = 1'b1; req1 = 1'b1; d0 = 8'h77; d1 = 8'h88;
    @(posedge c); #1;
    chk("tie_after_reset", {22'b0, gnt, lat_d}, {22'b0, 2'b01, 8'h77});
    req0 = 1'b0; req1 = 1'b0;
`ifdef LATCH_VERIFY_EN
    pulse_rst();
    chk("err_reset", {31'b0, err}, 32'h0);
    req0 = 1'b1; d0 = 8'h01;
    repeat (3) @(posedge c);
    #1 chk("err_hold", {31'b0, err}, 32'h0);
    @(posedge c); #1;
    chk("err_in_ack", {30'b0, ack0, err}, 32'h3);
    req0 = 1'b0;
    repeat (3) @(posedge c);
    #1 chk("err_sticky", {31'b0, err}, 32'h1);
    pulse_rst();
    chk("err_cleared", {31'b0, err}, 32'h0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
